fpmul_txn_master: RTL
=====================

// Module: fpmul_txn_master
// PURPOSE
//  Initiator side of the dut_if protocol used by the FPmul wrapper. Accepts operand pairs on an upstream
//  command port, drives them to the multiplier's input side with valid/ready, and collects the product
//  from the multiplier's output side. Returns {A,B,Z} on a response port. One transaction is outstanding
//  at a time. A watchdog aborts a hung transaction. Sits between a stimulus source (ROM/UART/bench) and the DUT.
// PARAMETERS
//  DATA_W       32    operand/result width (IEEE-754 single)
//  TIMEOUT_CYC  64    max cycles from entering ISSUE until result; reached -> abort
//  CNT_W        16    width of transaction/error counters
// PORTS
//  clk            in   1       single clock, all logic on posedge
//  rst            in   1       synchronous, active-high reset
//  cmd_valid      in   1       upstream operand pair valid
//  cmd_ready      out  1       master can accept a command
//  cmd_a          in   DATA_W  operand A
//  cmd_b          in   DATA_W  operand B
//  mul_a          out  DATA_W  to DUT input side A
//  mul_b          out  DATA_W  to DUT input side B
//  mul_in_valid   out  1       operands valid toward DUT
//  mul_in_ready   in   1       DUT ready for operands
//  mul_out_data   in   DATA_W  DUT product
//  mul_out_valid  in   1       DUT product valid (held until accepted)
//  mul_out_ready  out  1       master accepts product
//  rsp_valid      out  1       response valid
//  rsp_ready      in   1       downstream accepts response
//  rsp_a, rsp_b   out  DATA_W  echoed operands
//  rsp_z          out  DATA_W  product (0 on timeout)
//  rsp_timeout    out  1       response is an abort, rsp_z invalid
//  txn_count      out  CNT_W   completed responses, wraps modulo 2^CNT_W
//  err_count      out  CNT_W   timeouts, saturates at all-ones
// BEHAVIOUR
//  Registers: all outputs are registered. Reset forces every output to 0, state IDLE, timer 0, stale 0.
//   Reset mid-transaction abandons it silently, with no response and no counter update.
//  IDLE: cmd_ready=1 (0 while stale). On cmd_valid&cmd_ready: latch a/b into mul_a/mul_b and rsp_a/rsp_b,
//   cmd_ready<=0, mul_in_valid<=1, timer<=0, go to ISSUE. Accept cycle N -> mul_in_valid high at N+1.
//  ISSUE: hold mul_a/b stable while mul_in_valid=1. On mul_in_valid&mul_in_ready: mul_in_valid<=0,
//   mul_out_ready<=1, go to WAIT. The timer keeps running.
//  WAIT: on mul_out_valid&mul_out_ready: rsp_z<=mul_out_data, rsp_timeout<=0, mul_out_ready<=0,
//   rsp_valid<=1, go to RETURN.
//  Timeout: timer increments each cycle in ISSUE/WAIT. When timer==TIMEOUT_CYC-1 without completion:
//   drop mul_in_valid/mul_out_ready, rsp_z<=0, rsp_timeout<=1, rsp_valid<=1, go to RETURN.
//   If the abort happens in WAIT, set stale<=1.
//   A completion handshake in the same cycle as expiry wins; there is no timeout.
//  RETURN: hold rsp_* stable until rsp_ready. On handshake: rsp_valid<=0, txn_count++ (wrap),
//   err_count++ if rsp_timeout (saturating), go to IDLE. cmd_ready<=1 unless stale.
//  Stale drain: while stale and in IDLE, mul_out_ready=1. The first mul_out_valid handshake is discarded
//   and clears stale; cmd_ready rises the next cycle.
//  Min latency: cmd handshake to rsp_valid is 3 cycles plus DUT latency.
//   Back-to-back: the next cmd is accepted 1 cycle after the rsp handshake.
//  Protocol: valid never drops without a handshake except on timeout/reset. Data is stable while valid is high.
// STRUCTURE
//  Package fpmul_txn_pkg holds typedef enum logic[1:0] {IDLE,ISSUE,WAIT,RETURN} txn_state_t,
//   typedef logic[DATA_W-1:0] fp_word_t, and localparam FP_ZERO.
//  One sub-module, txn_watchdog, provides a clear/enable/expire counter of width $clog2(TIMEOUT_CYC).
// TESTING
//  1. A=0x40000000 (2.0), B=0x40400000 (3.0), DUT ready -> rsp_z=0x40C00000, rsp_timeout=0, txn_count=1.
//  2. Four commands back-to-back, rsp_ready always 1 -> 4 responses in order; each cmd_ready rise is 1 cycle
//     after the previous rsp handshake; txn_count=4.
//  3. mul_in_ready held 0 -> after 64 cycles in ISSUE: rsp_timeout=1, rsp_z=0, err_count=1, stale=0, next cmd accepted.
//  4. DUT never asserts mul_out_valid -> timeout response. A late mul_out_valid is discarded, then the next cmd
//     (1.5x2.0) returns 0x40400000.
//  5. rsp_ready held 0 for 10 cycles -> rsp_* stable, cmd_ready=0 throughout, counters unchanged until handshake.
//  6. rst asserted in WAIT -> next cycle all outputs 0, no response, counters 0; completion of a fresh cmd afterwards.

Source files
------------

// File: rtl/fpmul_txn_pkg.sv
// Shared types for the FPmul transaction master: FSM state encoding and
// the IEEE-754 single word type.
package fpmul_txn_pkg;
   localparam int FP_W = 32;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} txn_state_t;
   typedef logic [FP_W-1:0] fp_word_t;

   localparam fp_word_t FP_ZERO = '0;
endpackage

// File: rtl/txn_watchdog.sv
// Transaction watchdog: counts cycles while enabled and flags the last
// permitted cycle. The count holds at expiry instead of wrapping.
module txn_watchdog #(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam int TW = $clog2(TIMEOUT_CYC);

   logic [TW-1:0] timer;

   assign expire = en && (timer == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         timer <= '0;
      end else if (en && !expire) begin
         timer <= timer + 1'b1;
      end
   end
endmodule

// File: rtl/fpmul_txn_master.sv
// Initiator for the FPmul valid/ready wrapper: one outstanding operand pair,
// product returned with echoed operands, watchdog abort and stale-result drain.
//
//  state  | meaning
//  IDLE   | waiting for a command; drains a late product while stale
//  ISSUE  | operands presented to the multiplier
//  WAIT   | waiting for the product
//  RETURN | response presented downstream
module fpmul_txn_master
   import fpmul_txn_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 64,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   output logic [DATA_W-1:0] mul_a,
   output logic [DATA_W-1:0] mul_b,
   output logic              mul_in_valid,
   input  logic              mul_in_ready,
   input  logic [DATA_W-1:0] mul_out_data,
   input  logic              mul_out_valid,
   output logic              mul_out_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_a,
   output logic [DATA_W-1:0] rsp_b,
   output logic [DATA_W-1:0] rsp_z,
   output logic              rsp_timeout,
   output logic [CNT_W-1:0]  txn_count,
   output logic [CNT_W-1:0]  err_count
);
   txn_state_t        state, state_nxt;
   logic              stale, stale_nxt;
   logic              cmd_ready_nxt, mul_in_valid_nxt, mul_out_ready_nxt;
   logic              rsp_valid_nxt, rsp_timeout_nxt, abort;
   logic [DATA_W-1:0] mul_a_nxt, mul_b_nxt, rsp_a_nxt, rsp_b_nxt, rsp_z_nxt;
   logic [CNT_W-1:0]  txn_count_nxt, err_count_nxt;
   logic              wd_en, wd_expire;

   assign wd_en = (state == ISSUE) || (state == WAIT);

   txn_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
      .clk    (clk),
      .rst    (rst),
      .clr    (!wd_en),
      .en     (wd_en),
      .expire (wd_expire)
   );

   always_comb begin
      state_nxt         = state;
      stale_nxt         = stale;
      cmd_ready_nxt     = cmd_ready;
      mul_a_nxt         = mul_a;
      mul_b_nxt         = mul_b;
      mul_in_valid_nxt  = mul_in_valid;
      mul_out_ready_nxt = mul_out_ready;
      rsp_valid_nxt     = rsp_valid;
      rsp_a_nxt         = rsp_a;
      rsp_b_nxt         = rsp_b;
      rsp_z_nxt         = rsp_z;
      rsp_timeout_nxt   = rsp_timeout;
      txn_count_nxt     = txn_count;
      err_count_nxt     = err_count;
      abort             = 1'b0;
      unique case (state)
         IDLE: begin
            cmd_ready_nxt     = !stale;
            mul_out_ready_nxt = stale;
            if (stale && mul_out_valid && mul_out_ready) begin
               stale_nxt         = 1'b0;
               mul_out_ready_nxt = 1'b0;
               cmd_ready_nxt     = 1'b1;
            end else if (cmd_valid && cmd_ready) begin
               mul_a_nxt        = cmd_a;
               mul_b_nxt        = cmd_b;
               rsp_a_nxt        = cmd_a;
               rsp_b_nxt        = cmd_b;
               cmd_ready_nxt    = 1'b0;
               mul_in_valid_nxt = 1'b1;
               state_nxt        = ISSUE;
            end
         end
         ISSUE: begin
            // Operands taken on the expiry cycle still yield a product later.
            if (wd_expire) begin
               abort     = 1'b1;
               stale_nxt = mul_in_valid && mul_in_ready;
            end else if (mul_in_valid && mul_in_ready) begin
               mul_in_valid_nxt  = 1'b0;
               mul_out_ready_nxt = 1'b1;
               state_nxt         = WAIT;
            end
         end
         WAIT: begin
            if (mul_out_valid && mul_out_ready) begin
               rsp_z_nxt         = mul_out_data;
               rsp_timeout_nxt   = 1'b0;
               mul_out_ready_nxt = 1'b0;
               rsp_valid_nxt     = 1'b1;
               state_nxt         = RETURN;
            end else if (wd_expire) begin
               abort     = 1'b1;
               stale_nxt = 1'b1;
            end
         end
         RETURN: begin
            if (rsp_valid && rsp_ready) begin
               rsp_valid_nxt = 1'b0;
               txn_count_nxt = txn_count + 1'b1;
               if (rsp_timeout && (err_count != '1)) begin
                  err_count_nxt = err_count + 1'b1;
               end
               cmd_ready_nxt     = !stale;
               mul_out_ready_nxt = stale;
               state_nxt         = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (abort) begin
         mul_in_valid_nxt  = 1'b0;
         mul_out_ready_nxt = 1'b0;
         rsp_z_nxt         = DATA_W'(FP_ZERO);
         rsp_timeout_nxt   = 1'b1;
         rsp_valid_nxt     = 1'b1;
         state_nxt         = RETURN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         stale         <= 1'b0;
         cmd_ready     <= 1'b0;
         mul_a         <= '0;
         mul_b         <= '0;
         mul_in_valid  <= 1'b0;
         mul_out_ready <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_a         <= '0;
         rsp_b         <= '0;
         rsp_z         <= '0;
         rsp_timeout   <= 1'b0;
         txn_count     <= '0;
         err_count     <= '0;
      end else begin
         state         <= state_nxt;
         stale         <= stale_nxt;
         cmd_ready     <= cmd_ready_nxt;
         mul_a         <= mul_a_nxt;
         mul_b         <= mul_b_nxt;
         mul_in_valid  <= mul_in_valid_nxt;
         mul_out_ready <= mul_out_ready_nxt;
         rsp_valid     <= rsp_valid_nxt;
         rsp_a         <= rsp_a_nxt;
         rsp_b         <= rsp_b_nxt;
         rsp_z         <= rsp_z_nxt;
         rsp_timeout   <= rsp_timeout_nxt;
         txn_count     <= txn_count_nxt;
         err_count     <= err_count_nxt;
      end
   end
endmodule
